// File: rtl/cpu_pkg.sv
// Shared RV32I core constants and fetch-side types.
// Used by the fetch stage, its FIFOs and the fetch bus interface.
package cpu_pkg;

  localparam int XLEN       = 32;
  localparam int INST_ALIGN = 2;

  localparam logic [XLEN-1:0] NOP_INST_WORD    = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic {
    S_IDLE,
    S_FETCH
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:INST_ALIGN], {INST_ALIGN{1'b0}}};
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// Fetch-stage bus bundle: instruction-memory req/gnt/rvalid channel plus decode/execute side.
// master = fetch stage, slave = memory/decode/execute environment.
interface if_stage_if import cpu_pkg::*;;

  logic            imem_req_o;
  logic [XLEN-1:0] imem_addr_o;
  logic            imem_gnt_i;
  logic            imem_rvalid_i;
  logic [XLEN-1:0] imem_rdata_i;
  logic            redirect_i;
  logic [XLEN-1:0] redirect_pc_i;
  logic            stall_i;
  logic            valid_o;
  logic [XLEN-1:0] pc_o;
  logic [XLEN-1:0] inst_o;

  modport master (
    output imem_req_o, imem_addr_o, valid_o, pc_o, inst_o,
    input  imem_gnt_i, imem_rvalid_i, imem_rdata_i, redirect_i, redirect_pc_i, stall_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o, valid_o, pc_o, inst_o,
    output imem_gnt_i, imem_rvalid_i, imem_rdata_i, redirect_i, redirect_pc_i, stall_i
  );

endinterface

// File: rtl/fetch_fifo.sv
// Sync FIFO with flush and occupancy count; head is visible combinationally, write-to-read 1 cycle.
// No internal backpressure: pop on empty is ignored, push on full (without pop) is an error.
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_dat,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_dat,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_pop;
  logic             full;

  assign do_pop   = pop && (count != '0);
  assign full     = (count == CW'(DEPTH));
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: occupancy is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_dat;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    (push && !flush) |-> (!full || do_pop));

endmodule

// File: rtl/if_stage.sv
// RV32I fetch: credit-limited word fetches, in-order response queue, redirect flush with late-response discard.
// Latency 3 cycles reset-to-first-valid with 1-cycle memory; decode stall holds the head, redirect overrides stall.
module if_stage import cpu_pkg::*; #(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int              QDEPTH   = 2,
  parameter logic [XLEN-1:0] NOP_INST = NOP_INST_WORD
) (
  input  logic      clk,
  input  logic      rst_n,
  if_stage_if.master bus
);

  localparam int CW = $clog2(QDEPTH+1);

  fetch_state_e    state;
  logic [XLEN-1:0] fetch_pc;
  logic [CW-1:0]   inflight;
  logic [CW-1:0]   discard;
  logic [CW-1:0]   q_count;
  logic [CW-1:0]   tag_count;
  logic [XLEN-1:0] tag_head;
  fetch_entry_t    q_head;
  fetch_entry_t    q_push_dat;
  logic [CW:0]     credits_used;
  logic            req;
  logic            issue;
  logic            rsp_keep;
  logic            tag_pop;
  logic            q_pop;
  logic            q_valid;

  always_comb begin
    credits_used = {1'b0, q_count} + {1'b0, inflight};
    req          = (state == S_FETCH) && !bus.redirect_i && (credits_used < (CW+1)'(QDEPTH));
    issue        = req && bus.imem_gnt_i;
    tag_pop      = bus.imem_rvalid_i && (discard == '0);
    rsp_keep     = tag_pop && !bus.redirect_i;
    q_valid      = (q_count != '0);
    q_pop        = q_valid && !bus.stall_i;
    q_push_dat   = '{pc: tag_head, inst: bus.imem_rdata_i};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      fetch_pc <= RESET_PC;
      inflight <= '0;
      discard  <= '0;
    end else begin
      if (state == S_IDLE) state <= S_FETCH;
      inflight <= inflight + CW'(issue) - CW'(bus.imem_rvalid_i);
      if (bus.redirect_i) begin
        fetch_pc <= align_pc(bus.redirect_pc_i);
        // Everything still in flight after this cycle belongs to the old path.
        discard  <= inflight - CW'(bus.imem_rvalid_i);
      end else begin
        if (issue) fetch_pc <= fetch_pc + 32'd4;
        if (bus.imem_rvalid_i && (discard != '0)) discard <= discard - CW'(1);
      end
    end
  end

  fetch_fifo #(.WIDTH(XLEN), .DEPTH(QDEPTH)) u_tag_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (bus.redirect_i),
    .push     (issue),
    .push_dat (fetch_pc),
    .pop      (tag_pop),
    .head_dat (tag_head),
    .count    (tag_count)
  );

  fetch_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(QDEPTH)) u_inst_q (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (bus.redirect_i),
    .push     (rsp_keep),
    .push_dat (q_push_dat),
    .pop      (q_pop),
    .head_dat (q_head),
    .count    (q_count)
  );

  // Tags exist only for live fetches; discarded responses never had one after the flush.
  a_tag_track: assert property (@(posedge clk) disable iff (!rst_n)
    tag_count == (inflight - discard));

  assign bus.imem_req_o  = req;
  assign bus.imem_addr_o = fetch_pc;
  assign bus.valid_o     = q_valid;
  assign bus.pc_o        = q_valid ? q_head.pc   : '0;
  assign bus.inst_o      = q_valid ? q_head.inst : NOP_INST;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: fixed-latency memory returning addr>>2, hand-computed cycle-by-cycle expectations.
module tb_if_stage;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  if_stage_if bus();

  if_stage #(.RESET_PC(32'h0000_0000), .QDEPTH(2), .NOP_INST(32'h0000_0013)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int mem_lat  = 1;
  int cyc      = 0;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } rsp_t;
  rsp_t pend[$];

  // Memory: response presented mem_lat cycles after the issuing cycle, in order.
  initial begin
    bus.imem_rvalid_i = 1'b0;
    bus.imem_rdata_i  = '0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (pend.size() != 0 && pend[0].due == cyc) begin
        bus.imem_rvalid_i = 1'b1;
        bus.imem_rdata_i  = pend[0].addr >> 2;
        void'(pend.pop_front());
      end else begin
        bus.imem_rvalid_i = 1'b0;
      end
    end
  end

  initial begin
    rsp_t r;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend.delete();
      end else if (bus.imem_req_o && bus.imem_gnt_i) begin
        r.addr = bus.imem_addr_o;
        r.due  = cyc + mem_lat;
        pend.push_back(r);
      end
    end
  end

  task automatic cyc_start;
    @(posedge clk);
    #1;
  endtask

  task automatic cyc_mid;
    @(negedge clk);
  endtask

  // Leaves the caller at the start of cycle 0 (first cycle out of reset, IDLE).
  task automatic do_reset(input int lat, input logic gnt);
    cyc_start;
    rst_n = 1'b0;
    bus.redirect_i = 1'b0;
    bus.redirect_pc_i = '0;
    bus.stall_i = 1'b0;
    bus.imem_gnt_i = gnt;
    mem_lat = lat;
    repeat (3) cyc_start;
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    cyc_start;
    rst_n = 1'b0;
    bus.redirect_i = 1'b0;
    bus.stall_i = 1'b0;
    bus.imem_gnt_i = 1'b1;
    cyc_start;
    cyc_mid;
    n_checks++; if (bus.imem_req_o !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", bus.imem_req_o); end
    n_checks++; if (bus.valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus.valid_o); end
    n_checks++; if (bus.pc_o !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want 0", bus.pc_o); end
    n_checks++; if (bus.inst_o !== 32'h13) begin n_fail++; $display("FAIL reset_inst: got %h want 00000013", bus.inst_o); end
  endtask

  task automatic test_basic;
    do_reset(1, 1'b1);
    cyc_mid;
    n_checks++; if (bus.imem_req_o !== 1'b0) begin n_fail++; $display("FAIL basic_idle_req: got %b want 0", bus.imem_req_o); end
    cyc_start; cyc_mid;
    n_checks++; if ({bus.imem_req_o, bus.imem_addr_o} !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL basic_c1_req: got %b/%h want 1/00000000", bus.imem_req_o, bus.imem_addr_o); end
    cyc_start; cyc_mid;
    n_checks++; if ({bus.imem_req_o, bus.imem_addr_o} !== {1'b1, 32'h4}) begin n_fail++; $display("FAIL basic_c2_req: got %b/%h want 1/00000004", bus.imem_req_o, bus.imem_addr_o); end
    n_checks++; if (bus.valid_o !== 1'b0) begin n_fail++; $display("FAIL basic_c2_valid: got %b want 0", bus.valid_o); end
    cyc_start; cyc_mid;
    n_checks++; if ({bus.valid_o, bus.pc_o, bus.inst_o} !== {1'b1, 32'h0, 32'h0}) begin n_fail++; $display("FAIL basic_c3_head: got %b/%h/%h want 1/00000000/00000000", bus.valid_o, bus.pc_o, bus.inst_o); end
    n_checks++; if (bus.imem_req_o !== 1'b0) begin n_fail++; $display("FAIL basic_c3_credit: got req %b want 0", bus.imem_req_o); end
    cyc_start; cyc_mid;
    n_checks++; if ({bus.valid_o, bus.pc_o, bus.inst_o} !== {1'b1, 32'h4, 32'h1}) begin n_fail++; $display("FAIL basic_c4_head: got %b/%h/%h want 1/00000004/00000001", bus.valid_o, bus.pc_o, bus.inst_o); end
    n_checks++; if ({bus.imem_req_o, bus.imem_addr_o} !== {1'b1, 32'h8}) begin n_fail++; $display("FAIL basic_c4_req: got %b/%h want 1/00000008", bus.imem_req_o, bus.imem_addr_o); end
    cyc_start; cyc_mid;
    n_checks++; if (bus.valid_o !== 1'b0) begin n_fail++; $display("FAIL basic_c5_valid: got %b want 0", bus.valid_o); end
    cyc_start; cyc_mid;
    n_checks++; if ({bus.valid_o, bus.pc_o, bus.inst_o} !== {1'b1, 32'h8, 32'h2}) begin n_fail++; $display("FAIL basic_c6_head: got %b/%h/%h want 1/00000008/00000002", bus.valid_o, bus.pc_o, bus.inst_o); end
  endtask

  task automatic test_stall;
    do_reset(1, 1'b1);
    repeat (3) cyc_start;
    bus.stall_i = 1'b1;
    for (int c = 4; c <= 8; c++) begin
      cyc_start;
      if (c == 8) bus.stall_i = 1'b0;
      cyc_mid;
      n_checks++; if ({bus.valid_o, bus.pc_o, bus.imem_req_o} !== {1'b1, 32'h0, 1'b0}) begin n_fail++; $display("FAIL stall_hold c%0d: got v%b pc %h req %b want v1 pc 00000000 req 0", c, bus.valid_o, bus.pc_o, bus.imem_req_o); end
    end
    cyc_start; cyc_mid;
    n_checks++; if ({bus.valid_o, bus.pc_o, bus.inst_o} !== {1'b1, 32'h4, 32'h1}) begin n_fail++; $display("FAIL stall_c9_head: got %b/%h/%h want 1/00000004/00000001", bus.valid_o, bus.pc_o, bus.inst_o); end
    n_checks++; if ({bus.imem_req_o, bus.imem_addr_o} !== {1'b1, 32'h8}) begin n_fail++; $display("FAIL stall_c9_req: got %b/%h want 1/00000008", bus.imem_req_o, bus.imem_addr_o); end
    cyc_start; cyc_mid;
    n_checks++; if (bus.valid_o !== 1'b0) begin n_fail++; $display("FAIL stall_c10_valid: got %b want 0", bus.valid_o); end
    cyc_start;
    bus.stall_i = 1'b1;
    bus.redirect_i = 1'b1;
    bus.redirect_pc_i = 32'h40;
    cyc_mid;
    n_checks++; if ({bus.valid_o, bus.pc_o, bus.inst_o} !== {1'b1, 32'h8, 32'h2}) begin n_fail++; $display("FAIL stall_c11_head: got %b/%h/%h want 1/00000008/00000002", bus.valid_o, bus.pc_o, bus.inst_o); end
    n_checks++; if (bus.imem_req_o !== 1'b0) begin n_fail++; $display("FAIL stall_redirect_req: got %b want 0", bus.imem_req_o); end
    cyc_start;
    bus.stall_i = 1'b0;
    bus.redirect_i = 1'b0;
    cyc_mid;
    n_checks++; if (bus.valid_o !== 1'b0) begin n_fail++; $display("FAIL stall_flush_valid: got %b want 0", bus.valid_o); end
    n_checks++; if ({bus.imem_req_o, bus.imem_addr_o} !== {1'b1, 32'h40}) begin n_fail++; $display("FAIL stall_flush_req: got %b/%h want 1/00000040", bus.imem_req_o, bus.imem_addr_o); end
    cyc_start; cyc_start; cyc_mid;
    n_checks++; if ({bus.valid_o, bus.pc_o, bus.inst_o} !== {1'b1, 32'h40, 32'h10}) begin n_fail++; $display("FAIL stall_refetch_head: got %b/%h/%h want 1/00000040/00000010", bus.valid_o, bus.pc_o, bus.inst_o); end
  endtask

  task automatic test_gnt_wait;
    do_reset(1, 1'b0);
    for (int c = 1; c <= 4; c++) begin
      cyc_start;
      if (c == 4) bus.imem_gnt_i = 1'b1;
      cyc_mid;
      n_checks++; if ({bus.imem_req_o, bus.imem_addr_o} !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL gnt_hold c%0d: got %b/%h want 1/00000000", c, bus.imem_req_o, bus.imem_addr_o); end
    end
    cyc_start; cyc_mid;
    n_checks++; if ({bus.imem_req_o, bus.imem_addr_o} !== {1'b1, 32'h4}) begin n_fail++; $display("FAIL gnt_advance: got %b/%h want 1/00000004", bus.imem_req_o, bus.imem_addr_o); end
    cyc_start; cyc_mid;
    n_checks++; if ({bus.valid_o, bus.pc_o, bus.inst_o} !== {1'b1, 32'h0, 32'h0}) begin n_fail++; $display("FAIL gnt_head: got %b/%h/%h want 1/00000000/00000000", bus.valid_o, bus.pc_o, bus.inst_o); end
  endtask

  task automatic test_redirect_inflight;
    do_reset(3, 1'b1);
    bus.redirect_i = 1'b1;
    bus.redirect_pc_i = 32'h10;
    cyc_start;
    bus.redirect_i = 1'b0;
    cyc_mid;
    n_checks++; if ({bus.imem_req_o, bus.imem_addr_o} !== {1'b1, 32'h10}) begin n_fail++; $display("FAIL rdi_c1_req: got %b/%h want 1/00000010", bus.imem_req_o, bus.imem_addr_o); end
    cyc_start; cyc_mid;
    n_checks++; if ({bus.imem_req_o, bus.imem_addr_o} !== {1'b1, 32'h14}) begin n_fail++; $display("FAIL rdi_c2_req: got %b/%h want 1/00000014", bus.imem_req_o, bus.imem_addr_o); end
    cyc_start;
    bus.redirect_i = 1'b1;
    bus.redirect_pc_i = 32'h103;
    cyc_mid;
    n_checks++; if (bus.imem_req_o !== 1'b0) begin n_fail++; $display("FAIL rdi_c3_req: got %b want 0", bus.imem_req_o); end
    for (int c = 4; c <= 8; c++) begin
      cyc_start;
      bus.redirect_i = 1'b0;
      cyc_mid;
      n_checks++; if (bus.valid_o !== 1'b0) begin n_fail++; $display("FAIL rdi_drop c%0d: got valid %b pc %h want valid 0", c, bus.valid_o, bus.pc_o); end
      if (c == 5) begin
        n_checks++; if ({bus.imem_req_o, bus.imem_addr_o} !== {1'b1, 32'h100}) begin n_fail++; $display("FAIL rdi_c5_req: got %b/%h want 1/00000100", bus.imem_req_o, bus.imem_addr_o); end
      end
    end
    cyc_start; cyc_mid;
    n_checks++; if ({bus.valid_o, bus.pc_o, bus.inst_o} !== {1'b1, 32'h100, 32'h40}) begin n_fail++; $display("FAIL rdi_head: got %b/%h/%h want 1/00000100/00000040", bus.valid_o, bus.pc_o, bus.inst_o); end
  endtask

  task automatic test_redirect_pop;
    do_reset(1, 1'b1);
    repeat (3) cyc_start;
    bus.redirect_i = 1'b1;
    bus.redirect_pc_i = 32'h200;
    cyc_mid;
    n_checks++; if ({bus.valid_o, bus.pc_o, bus.imem_rvalid_i} !== {1'b1, 32'h0, 1'b1}) begin n_fail++; $display("FAIL rdp_setup: got v%b pc %h rvalid %b want v1 pc 00000000 rvalid 1", bus.valid_o, bus.pc_o, bus.imem_rvalid_i); end
    cyc_start;
    bus.redirect_i = 1'b0;
    cyc_mid;
    n_checks++; if ({bus.valid_o, bus.pc_o, bus.inst_o} !== {1'b0, 32'h0, 32'h13}) begin n_fail++; $display("FAIL rdp_empty: got %b/%h/%h want 0/00000000/00000013", bus.valid_o, bus.pc_o, bus.inst_o); end
    n_checks++; if ({bus.imem_req_o, bus.imem_addr_o} !== {1'b1, 32'h200}) begin n_fail++; $display("FAIL rdp_req: got %b/%h want 1/00000200", bus.imem_req_o, bus.imem_addr_o); end
    cyc_start; cyc_start; cyc_mid;
    n_checks++; if ({bus.valid_o, bus.pc_o, bus.inst_o} !== {1'b1, 32'h200, 32'h80}) begin n_fail++; $display("FAIL rdp_head: got %b/%h/%h want 1/00000200/00000080", bus.valid_o, bus.pc_o, bus.inst_o); end
  endtask

  task automatic test_wrap;
    do_reset(1, 1'b1);
    bus.redirect_i = 1'b1;
    bus.redirect_pc_i = 32'hFFFF_FFFC;
    cyc_start;
    bus.redirect_i = 1'b0;
    cyc_mid;
    n_checks++; if ({bus.imem_req_o, bus.imem_addr_o} !== {1'b1, 32'hFFFF_FFFC}) begin n_fail++; $display("FAIL wrap_req0: got %b/%h want 1/fffffffc", bus.imem_req_o, bus.imem_addr_o); end
    cyc_start; cyc_mid;
    n_checks++; if ({bus.imem_req_o, bus.imem_addr_o} !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL wrap_req1: got %b/%h want 1/00000000", bus.imem_req_o, bus.imem_addr_o); end
    cyc_start; cyc_mid;
    n_checks++; if ({bus.valid_o, bus.pc_o, bus.inst_o} !== {1'b1, 32'hFFFF_FFFC, 32'h3FFF_FFFF}) begin n_fail++; $display("FAIL wrap_head0: got %b/%h/%h want 1/fffffffc/3fffffff", bus.valid_o, bus.pc_o, bus.inst_o); end
    cyc_start; cyc_mid;
    n_checks++; if ({bus.valid_o, bus.pc_o, bus.inst_o} !== {1'b1, 32'h0, 32'h0}) begin n_fail++; $display("FAIL wrap_head1: got %b/%h/%h want 1/00000000/00000000", bus.valid_o, bus.pc_o, bus.inst_o); end
  endtask

  initial begin
    bus.imem_gnt_i    = 1'b0;
    bus.redirect_i    = 1'b0;
    bus.redirect_pc_i = '0;
    bus.stall_i       = 1'b0;
    test_reset;
    test_basic;
    test_stall;
    test_reset;
    test_gnt_wait;
    test_redirect_inflight;
    test_redirect_pop;
    test_wrap;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
